// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: datapath widths, RV32I load/store
// funct3 encodings, write-back source select codes and the pipeline payload.
package mem_wb_stage_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [1:0]            wb_sel;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] wr_data;
    } wb_pipe_t;

endpackage

// File: rtl/mem_wb_stage_load_aligner.sv
// Load aligner: picks the addressed byte/half out of a word-aligned read word
// and sign/zero-extends it; flags misaligned half/word accesses.
// Ports:
//   word_i     read word from memory (unshifted)
//   funct3_i   load width/sign
//   addr_i     low two address bits
//   data_o     aligned, extended load value
//   misalign_o access not naturally aligned
module mem_wb_stage_load_aligner
    import mem_wb_stage_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte and half-word lane selection
    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extension and misalignment detection
    always_comb begin
        data_o     = word_i;
        misalign_o = 1'b0;
        case (funct3_i)
            FUNCT3_LB:  data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            FUNCT3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            FUNCT3_LH: begin
                data_o     = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                misalign_o = addr_i[0];
            end
            FUNCT3_LHU: begin
                data_o     = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                misalign_o = addr_i[0];
            end
            FUNCT3_LW: begin
                data_o     = word_i;
                misalign_o = (addr_i != 2'b00);
            end
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back datapath.
// Captures MEM-stage control/results, holds the synchronous memory read word
// across stalls, aligns load data, selects the register write-back value and
// drives the whole-word store-forwarding ports of data_memory.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   stall_i, flush_i     hold WB state / squash incoming instruction
//   MEM_*_i              MEM-stage control and data
//   rd_data_i            data_memory read word (valid while load is in WB)
//   WB_valid_o           WB holds a real instruction
//   WB_RegWrite_o        register-file write enable
//   WB_rd_addr_o         register-file write index
//   WB_wb_data_o         register-file write data
//   WB_load_misalign_o   misaligned-load exception
//   WB_MemWrite_en_o, WB_addr_o, WB_wr_data_o   store forwarding to data_memory
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  MEM_valid_i,
    input  logic                  MEM_RegWrite_i,
    input  logic                  MEM_MemRead_i,
    input  logic                  MEM_MemWrite_i,
    input  logic [1:0]            MEM_wb_sel_i,
    input  logic [2:0]            MEM_funct3_i,
    input  logic [REG_ADDR_W-1:0] MEM_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_pc_plus4_i,
    input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  WB_valid_o,
    output logic                  WB_RegWrite_o,
    output logic [REG_ADDR_W-1:0] WB_rd_addr_o,
    output logic [DATA_WIDTH-1:0] WB_wb_data_o,
    output logic                  WB_load_misalign_o,
    output logic                  WB_MemWrite_en_o,
    output logic [DATA_WIDTH-1:0] WB_addr_o,
    output logic [DATA_WIDTH-1:0] WB_wr_data_o
);

    wb_pipe_t              pipe_q, pipe_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_v_q, hold_v_d;

    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  align_misalign;
    logic                  misalign;

    // Pipeline and hold-register next state; stall has priority over flush
    always_comb begin
        pipe_d   = pipe_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        if (!stall_i) begin
            pipe_d.valid      = MEM_valid_i;
            pipe_d.reg_write  = MEM_RegWrite_i;
            pipe_d.mem_read   = MEM_MemRead_i;
            pipe_d.mem_write  = MEM_MemWrite_i;
            pipe_d.wb_sel     = MEM_wb_sel_i;
            pipe_d.funct3     = MEM_funct3_i;
            pipe_d.rd_addr    = MEM_rd_addr_i;
            pipe_d.alu_result = MEM_alu_result_i;
            pipe_d.pc_plus4   = MEM_pc_plus4_i;
            pipe_d.wr_data    = MEM_wr_data_i;
            if (flush_i) begin
                pipe_d.valid     = 1'b0;
                pipe_d.reg_write = 1'b0;
                pipe_d.mem_read  = 1'b0;
                pipe_d.mem_write = 1'b0;
            end
            hold_v_d = 1'b0;
        end else if (pipe_q.valid && pipe_q.mem_read && !hold_v_q) begin
            // Memory read port moves on after this cycle; keep the word
            hold_d   = rd_data_i;
            hold_v_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q   <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            pipe_q   <= pipe_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

    assign load_word = hold_v_q ? hold_q : rd_data_i;

    mem_wb_stage_load_aligner u_load_aligner (
        .word_i     (load_word),
        .funct3_i   (pipe_q.funct3),
        .addr_i     (pipe_q.alu_result[1:0]),
        .data_o     (load_data),
        .misalign_o (align_misalign)
    );

    assign misalign = pipe_q.valid && pipe_q.mem_read && align_misalign;

    // Write-back source select
    always_comb begin
        WB_wb_data_o = '0;
        case (pipe_q.wb_sel)
            WB_SEL_ALU: WB_wb_data_o = pipe_q.alu_result;
            WB_SEL_MEM: WB_wb_data_o = load_data;
            WB_SEL_PC4: WB_wb_data_o = pipe_q.pc_plus4;
            default:    WB_wb_data_o = '0;
        endcase
    end

    assign WB_valid_o         = pipe_q.valid;
    assign WB_rd_addr_o       = pipe_q.rd_addr;
    assign WB_load_misalign_o = misalign;
    assign WB_RegWrite_o      = pipe_q.valid && pipe_q.reg_write
                                && (pipe_q.rd_addr != '0) && !misalign;
    // Forwarding path only carries whole words, so sub-word stores stay out
    assign WB_MemWrite_en_o   = pipe_q.valid && pipe_q.mem_write
                                && (pipe_q.funct3 == FUNCT3_SW);
    assign WB_addr_o          = pipe_q.alu_result;
    assign WB_wr_data_o       = pipe_q.wr_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i;
    logic        MEM_valid_i, MEM_RegWrite_i, MEM_MemRead_i, MEM_MemWrite_i;
    logic [1:0]  MEM_wb_sel_i;
    logic [2:0]  MEM_funct3_i;
    logic [4:0]  MEM_rd_addr_i;
    logic [31:0] MEM_alu_result_i, MEM_pc_plus4_i, MEM_wr_data_i, rd_data_i;
    logic        WB_valid_o, WB_RegWrite_o, WB_load_misalign_o, WB_MemWrite_en_o;
    logic [4:0]  WB_rd_addr_o;
    logic [31:0] WB_wb_data_o, WB_addr_o, WB_wr_data_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .MEM_valid_i        (MEM_valid_i),
        .MEM_RegWrite_i     (MEM_RegWrite_i),
        .MEM_MemRead_i      (MEM_MemRead_i),
        .MEM_MemWrite_i     (MEM_MemWrite_i),
        .MEM_wb_sel_i       (MEM_wb_sel_i),
        .MEM_funct3_i       (MEM_funct3_i),
        .MEM_rd_addr_i      (MEM_rd_addr_i),
        .MEM_alu_result_i   (MEM_alu_result_i),
        .MEM_pc_plus4_i     (MEM_pc_plus4_i),
        .MEM_wr_data_i      (MEM_wr_data_i),
        .rd_data_i          (rd_data_i),
        .WB_valid_o         (WB_valid_o),
        .WB_RegWrite_o      (WB_RegWrite_o),
        .WB_rd_addr_o       (WB_rd_addr_o),
        .WB_wb_data_o       (WB_wb_data_o),
        .WB_load_misalign_o (WB_load_misalign_o),
        .WB_MemWrite_en_o   (WB_MemWrite_en_o),
        .WB_addr_o          (WB_addr_o),
        .WB_wr_data_o       (WB_wr_data_o)
    );

    typedef struct {
        string       name;
        logic        valid, rw, mr, mw;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, pc4, wdata, rdata;
        logic        e_valid, e_rw, e_mis, e_mwen;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] wd);
        MEM_valid_i      = v;
        MEM_RegWrite_i   = rw;
        MEM_MemRead_i    = mr;
        MEM_MemWrite_i   = mw;
        MEM_wb_sel_i     = sel;
        MEM_funct3_i     = f3;
        MEM_rd_addr_i    = rd;
        MEM_alu_result_i = alu;
        MEM_pc_plus4_i   = pc4;
        MEM_wr_data_i    = wd;
    endtask

    function automatic vec_t mk(input string n, input logic v, input logic rw, input logic mr,
                                input logic mw, input logic [1:0] sel, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                                input logic [31:0] wd, input logic [31:0] rdat, input logic ev,
                                input logic erw, input logic emis, input logic emw,
                                input logic [31:0] ed);
        vec_t t;
        t.name = n; t.valid = v; t.rw = rw; t.mr = mr; t.mw = mw; t.sel = sel; t.f3 = f3;
        t.rd = rd; t.alu = alu; t.pc4 = pc4; t.wdata = wd; t.rdata = rdat;
        t.e_valid = ev; t.e_rw = erw; t.e_mis = emis; t.e_mwen = emw; t.e_data = ed;
        return t;
    endfunction

    // Load a MEM-stage instruction, let it reach WB, present the read word
    task automatic step_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        @(negedge clk);
        drive(1, 1, 1, 0, WB_SEL_MEM, f3, 5'd7, addr, 32'h0, 32'h0);
        rd_data_i = 32'h0;
        @(posedge clk);
        #1 rd_data_i = word;
        #1;
    endtask

    initial begin
        //         name        v rw mr mw sel         f3          rd  alu           pc4           wdata         rdata         ev rw mis mwen data
        vecs[0]  = mk("lb103",  1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LB,  5,  32'h103,      32'h0,        32'h0,        32'h80FF1234, 1, 1, 0, 0, 32'hFFFFFF80);
        vecs[1]  = mk("lhu102", 1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LHU, 6,  32'h102,      32'h0,        32'h0,        32'hBEEFCAFE, 1, 1, 0, 0, 32'h0000BEEF);
        vecs[2]  = mk("lh102",  1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LH,  6,  32'h102,      32'h0,        32'h0,        32'hBEEFCAFE, 1, 1, 0, 0, 32'hFFFFBEEF);
        vecs[3]  = mk("lw201",  1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LW,  8,  32'h201,      32'h0,        32'h0,        32'h11223344, 1, 0, 1, 0, 32'h11223344);
        vecs[4]  = mk("lbu101", 1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LBU, 9,  32'h101,      32'h0,        32'h0,        32'h123480AB, 1, 1, 0, 0, 32'h00000080);
        vecs[5]  = mk("lb100",  1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LB,  9,  32'h100,      32'h0,        32'h0,        32'hFFFFFF7F, 1, 1, 0, 0, 32'h0000007F);
        vecs[6]  = mk("lh100",  1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LH,  10, 32'h100,      32'h0,        32'h0,        32'h12348001, 1, 1, 0, 0, 32'hFFFF8001);
        vecs[7]  = mk("lhu103", 1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LHU, 10, 32'h103,      32'h0,        32'h0,        32'hA5A5A5A5, 1, 0, 1, 0, 32'h0000A5A5);
        vecs[8]  = mk("lw200",  1, 1, 1, 0, WB_SEL_MEM, FUNCT3_LW,  11, 32'h200,      32'h0,        32'h0,        32'hCAFEF00D, 1, 1, 0, 0, 32'hCAFEF00D);
        vecs[9]  = mk("add",    1, 1, 0, 0, WB_SEL_ALU, 3'b000,     3,  32'h12345678, 32'h0,        32'h0,        32'hFFFFFFFF, 1, 1, 0, 0, 32'h12345678);
        vecs[10] = mk("add_x0", 1, 1, 0, 0, WB_SEL_ALU, 3'b000,     0,  32'h00000055, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 32'h00000055);
        vecs[11] = mk("jal",    1, 1, 0, 0, WB_SEL_PC4, 3'b000,     1,  32'h00000800, 32'h00000104, 32'h0,        32'h0,        1, 1, 0, 0, 32'h00000104);
        vecs[12] = mk("sel11",  1, 1, 0, 0, 2'b11,      3'b000,     2,  32'h00000999, 32'h00000777, 32'h0,        32'h0,        1, 1, 0, 0, 32'h00000000);
        vecs[13] = mk("sw",     1, 0, 0, 1, WB_SEL_ALU, FUNCT3_SW,  0,  32'h00000400, 32'h0,        32'hFFFFFFFF, 32'h0,        1, 0, 0, 1, 32'h00000400);
        vecs[14] = mk("sb",     1, 0, 0, 1, WB_SEL_ALU, FUNCT3_SB,  0,  32'h00000401, 32'h0,        32'h000000AA, 32'h0,        1, 0, 0, 0, 32'h00000401);
        vecs[15] = mk("bubble", 0, 1, 0, 0, WB_SEL_ALU, 3'b000,     4,  32'h00000042, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 32'h00000042);

        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; rd_data_i = 32'h0;
        drive(0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    32'(WB_valid_o), 32'h0);
        chk("rst_regwrite", 32'(WB_RegWrite_o), 32'h0);
        chk("rst_wbdata",   WB_wb_data_o, 32'h0);
        chk("rst_mwen",     32'(WB_MemWrite_en_o), 32'h0);
        @(negedge clk) rst = 1'b0;

        // Table-driven single-instruction vectors
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].sel, vecs[i].f3,
                  vecs[i].rd, vecs[i].alu, vecs[i].pc4, vecs[i].wdata);
            rd_data_i = 32'h0;
            @(posedge clk);
            #1 rd_data_i = vecs[i].rdata;
            #1;
            chk({vecs[i].name, "_valid"},  32'(WB_valid_o), 32'(vecs[i].e_valid));
            chk({vecs[i].name, "_rw"},     32'(WB_RegWrite_o), 32'(vecs[i].e_rw));
            chk({vecs[i].name, "_mis"},    32'(WB_load_misalign_o), 32'(vecs[i].e_mis));
            chk({vecs[i].name, "_mwen"},   32'(WB_MemWrite_en_o), 32'(vecs[i].e_mwen));
            chk({vecs[i].name, "_data"},   WB_wb_data_o, vecs[i].e_data);
            chk({vecs[i].name, "_rdaddr"}, 32'(WB_rd_addr_o), 32'(vecs[i].rd));
            chk({vecs[i].name, "_addr"},   WB_addr_o, vecs[i].alu);
            chk({vecs[i].name, "_wdata"},  WB_wr_data_o, vecs[i].wdata);
        end

        // LW held in WB over a 3-cycle stall while the read port changes
        step_load(FUNCT3_LW, 32'h200, 32'hDEADBEEF);
        chk("stall_pre", WB_wb_data_o, 32'hDEADBEEF);
        @(negedge clk);
        stall_i = 1'b1;
        drive(1, 1, 0, 0, WB_SEL_ALU, 3'b000, 5'd3, 32'h00001111, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 rd_data_i = 32'h0;
            #1;
            chk("stall_data",  WB_wb_data_o, 32'hDEADBEEF);
            chk("stall_valid", 32'(WB_valid_o), 32'h1);
            chk("stall_rd",    32'(WB_rd_addr_o), 32'd7);
        end
        @(negedge clk) stall_i = 1'b0;
        @(posedge clk);
        #1;
        chk("unstall_data", WB_wb_data_o, 32'h00001111);
        chk("unstall_rd",   32'(WB_rd_addr_o), 32'd3);

        // Flush of a valid ADD inserts a bubble
        @(negedge clk);
        flush_i = 1'b1;
        drive(1, 1, 0, 0, WB_SEL_ALU, 3'b000, 5'd4, 32'h00002222, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("flush_valid", 32'(WB_valid_o), 32'h0);
        chk("flush_rw",    32'(WB_RegWrite_o), 32'h0);

        // Flush is ignored while stalled: the WB-stage ADD is kept
        @(negedge clk);
        flush_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        stall_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1;
        chk("stallflush_valid", 32'(WB_valid_o), 32'h1);
        chk("stallflush_rw",    32'(WB_RegWrite_o), 32'h1);
        @(negedge clk);
        stall_i = 1'b0; flush_i = 1'b0;

        // Reset asserted while a held load sits in a stall
        step_load(FUNCT3_LW, 32'h300, 32'h87654321);
        @(negedge clk) stall_i = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rststall_valid", 32'(WB_valid_o), 32'h0);
        chk("rststall_rw",    32'(WB_RegWrite_o), 32'h0);
        chk("rststall_data",  WB_wb_data_o, 32'h0);
        chk("rststall_addr",  WB_addr_o, 32'h0);
        chk("rststall_rd",    32'(WB_rd_addr_o), 32'h0);
        @(negedge clk);
        rst = 1'b0; stall_i = 1'b0;
        step_load(FUNCT3_LW, 32'h300, 32'h55AA55AA);
        chk("postrst_data", WB_wb_data_o, 32'h55AA55AA);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
